// File: rtl/spi_ram_bridge_p.sv
// SPI slave front end merged with a single-port RAM: frames of 2+W bits carry a
// 2-bit command and a W-bit payload; reads stream a RAM word back on MISO.
module spi_ram_bridge_p #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int W     = DATA_WIDTH;
  localparam int A     = ADDR_WIDTH;
  localparam int FW    = W + 2;
  localparam int CW    = $clog2(FW);
  localparam int DEPTH = 1 << A;

  localparam logic [CW-1:0] RX_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] TX_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RX,
    RD_WAIT,
    TX
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [CW-1:0]  r_cnt;
  logic [W:0]     r_rxShift;
  logic [FW-1:0]  w_frame;
  logic [1:0]     w_cmd;
  logic           w_frameDone;
  logic           w_inFrame;

  logic [A-1:0]   r_wrAddr;
  logic [A-1:0]   r_rdAddr;
  logic           r_pendValid;
  logic [1:0]     r_pendCmd;
  logic [W-1:0]   r_pendData;
  logic           r_frameErr;

  logic           w_ramWe;
  logic           w_ramRe;
  logic [A-1:0]   w_ramAddr;
  logic [W-1:0]   r_mem [DEPTH];
  logic [W-1:0]   r_ramQ;
  logic [W-1:0]   w_txWord;

  // The frame is assembled combinationally so the completing bit can be decoded on its own edge.
  assign w_frame     = {r_rxShift, MOSI};
  assign w_cmd       = w_frame[FW-1:FW-2];
  assign w_frameDone = (r_state == IDLE || r_state == RX) && !SS_n && (r_cnt == RX_LAST);
  assign w_inFrame   = (r_state == RX && r_cnt != '0) || (r_state == RD_WAIT) || (r_state == TX);

  assign busy      = w_inFrame;
  assign frame_err = r_frameErr;
  assign w_txWord  = r_ramQ << r_cnt;
  assign MISO      = (r_state == TX) & w_txWord[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (SS_n) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nextState = RX;
        RX:      if (w_frameDone && w_cmd == 2'b11) w_nextState = RD_WAIT;
        RD_WAIT: w_nextState = TX;
        TX:      if (r_cnt == TX_LAST) w_nextState = RX;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Completed non-read frames are parked for one cycle and applied on the following edge,
  // which lets the next frame start immediately and still lets a frame ending at SS_n rise commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rxShift   <= '0;
      r_wrAddr    <= '0;
      r_rdAddr    <= '0;
      r_pendValid <= 1'b0;
      r_pendCmd   <= 2'b00;
      r_pendData  <= '0;
      r_frameErr  <= 1'b0;
    end else begin
      r_frameErr  <= SS_n && w_inFrame;
      r_pendValid <= 1'b0;
      if (r_pendValid) begin
        case (r_pendCmd)
          2'b00:   r_wrAddr <= r_pendData[A-1:0];
          2'b01:   if (AUTO_INC != 0) r_wrAddr <= r_wrAddr + A'(1);
          2'b10:   r_rdAddr <= r_pendData[A-1:0];
          default: ;
        endcase
      end
      if (SS_n) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          IDLE, RX: begin
            r_rxShift <= w_frame[W:0];
            if (w_frameDone) begin
              r_cnt       <= '0;
              r_pendValid <= (w_cmd != 2'b11);
              r_pendCmd   <= w_cmd;
              r_pendData  <= w_frame[W-1:0];
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          RD_WAIT: begin
            r_cnt <= '0;
            if (AUTO_INC != 0) r_rdAddr <= r_rdAddr + A'(1);
          end
          TX:      r_cnt <= (r_cnt == TX_LAST) ? '0 : r_cnt + CW'(1);
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  // Single shared address port; a write and a read can never fall in the same cycle.
  assign w_ramWe   = !rst && r_pendValid && (r_pendCmd == 2'b01);
  assign w_ramRe   = !rst && !SS_n && (r_state == RD_WAIT);
  assign w_ramAddr = w_ramWe ? r_wrAddr : r_rdAddr;

  always_ff @(posedge clk) begin
    if (w_ramWe) r_mem[w_ramAddr] <= r_pendData;
    if (w_ramRe) r_ramQ <= r_mem[w_ramAddr];
  end

endmodule
